// File: rtl/fpu_pkg.sv
// Shared FP-compare types: op encoding, IEEE-754 single constants, and the result-routing tag.
package fpu_pkg;

    typedef enum logic [1:0] {
        FCMP_EQ  = 2'd0,
        FCMP_LT  = 2'd1,
        FCMP_LE  = 2'd2,
        FCMP_RSV = 2'd3
    } fcmp_op_t;

    localparam logic [31:0] FP_ONE  = 32'h3f80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef struct packed {
        logic       v;
        logic [2:0] id;
    } fcmp_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant of the first requester at or after the pointer.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          sys_clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_id
);

    logic [PW-1:0] ptr;
    logic          found;
    int            idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = PW'(idx);
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rstn)
            ptr <= '0;
        else if (found)
            ptr <= (gnt_id == PW'(N - 1)) ? '0 : gnt_id + PW'(1);
    end

endmodule

// File: rtl/fcmp_arbiter.sv
// Shares one pipelined FP compare unit among N requesters with per-requester result slots.
// Optional protocol checker enabled by defining FCMP_ARB_CHECK_EN; otherwise err is tied low.
module fcmp_arbiter
    import fpu_pkg::*;
#(
    parameter int N   = 2,
    parameter int LAT = 1
) (
    input  logic            sys_clk,
    input  logic            rstn,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [2*N-1:0]  req_op,
    input  logic [32*N-1:0] req_x1,
    input  logic [32*N-1:0] req_x2,
    output logic [N-1:0]    rsp_valid,
    output logic [32*N-1:0] rsp_y,
    input  logic [N-1:0]    rsp_ready,
    output logic            cmp_valid,
    output logic [1:0]      cmp_op,
    output logic [31:0]     cmp_x1,
    output logic [31:0]     cmp_x2,
    input  logic [31:0]     cmp_y,
    input  logic            cmp_out_valid,
    output logic            err
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  pending;
    logic [N-1:0]  eligible;
    logic [N-1:0]  gnt;
    logic [PW-1:0] gnt_id;
    logic [N-1:0]  rsp_fire;
    logic [PW-1:0] wb_id;
    fcmp_tag_t     tag_pipe [LAT+1];
    logic          tag_unused;

    assign eligible  = req_valid & ~pending;
    assign rsp_fire  = rsp_valid & rsp_ready;
    assign req_ready = gnt;

    // Arbitration is gated by rstn so nothing is accepted while reset is held.
    rr_arbiter #(.N(N)) u_rr (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .req     (eligible),
        .en      (rstn),
        .gnt     (gnt),
        .gnt_id  (gnt_id)
    );

    always_ff @(posedge sys_clk) begin
        if (!rstn)
            cmp_valid <= 1'b0;
        else
            cmp_valid <= |gnt;
    end

    always_ff @(posedge sys_clk) begin
        cmp_op <= req_op[2*int'(gnt_id) +: 2];
        cmp_x1 <= req_x1[32*int'(gnt_id) +: 32];
        cmp_x2 <= req_x2[32*int'(gnt_id) +: 32];
    end

    // Stage 0 travels alongside cmp_valid, so stage LAT lines up with cmp_out_valid.
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            for (int k = 0; k <= LAT; k++)
                tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0].v  <= |gnt;
            tag_pipe[0].id <= 3'(gnt_id);
            for (int k = 1; k <= LAT; k++)
                tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    assign wb_id      = tag_pipe[LAT].id[PW-1:0];
    assign tag_unused = ^tag_pipe[LAT];

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            pending   <= '0;
            rsp_valid <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i])
                    pending[i] <= 1'b1;
                else if (rsp_fire[i])
                    pending[i] <= 1'b0;

                if (cmp_out_valid && wb_id == PW'(i))
                    rsp_valid[i] <= 1'b1;
                else if (rsp_fire[i])
                    rsp_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (cmp_out_valid)
            rsp_y[32*int'(wb_id) +: 32] <= cmp_y;
    end

`ifdef FCMP_ARB_CHECK_EN
    logic err_q;
    logic err_hit;

    assign err_hit = (cmp_out_valid != tag_pipe[LAT].v)
                   | (cmp_out_valid & rsp_valid[wb_id])
                   | ((|gnt) & (fcmp_op_t'(req_op[2*int'(gnt_id) +: 2]) == FCMP_RSV));

    always_ff @(posedge sys_clk) begin
        if (!rstn)
            err_q <= 1'b0;
        else if (err_hit)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed bench for fcmp_arbiter (N=2, LAT=1) with a behavioural single-cycle compare unit.
module tb_fcmp_arbiter;

    localparam int N   = 2;
    localparam int LAT = 1;
`ifdef FCMP_ARB_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            sys_clk;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [32*N-1:0] req_x1;
    logic [32*N-1:0] req_x2;
    logic [N-1:0]    rsp_valid;
    logic [32*N-1:0] rsp_y;
    logic [N-1:0]    rsp_ready;
    logic            cmp_valid;
    logic [1:0]      cmp_op;
    logic [31:0]     cmp_x1;
    logic [31:0]     cmp_x2;
    logic [31:0]     cmp_y;
    logic            cmp_out_valid;
    logic            err;

    logic            inject;
    logic            u_v;
    logic [31:0]     u_y;

    int checks = 0;
    int errors = 0;

    fcmp_arbiter #(.N(N), .LAT(LAT)) dut (
        .sys_clk       (sys_clk),
        .rstn          (rstn),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_x1        (req_x1),
        .req_x2        (req_x2),
        .rsp_valid     (rsp_valid),
        .rsp_y         (rsp_y),
        .rsp_ready     (rsp_ready),
        .cmp_valid     (cmp_valid),
        .cmp_op        (cmp_op),
        .cmp_x1        (cmp_x1),
        .cmp_x2        (cmp_x2),
        .cmp_y         (cmp_y),
        .cmp_out_valid (cmp_out_valid),
        .err           (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Ordering key: maps IEEE single bits to an unsigned value that sorts like the float.
    function automatic logic [31:0] fkey(input logic [31:0] b);
        return b[31] ? ~b : (b | 32'h8000_0000);
    endfunction

    function automatic logic [31:0] fcmp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic eq, lt;
        eq = (a == b) || ((a[30:0] == 31'd0) && (b[30:0] == 31'd0));
        lt = !eq && (fkey(a) < fkey(b));
        case (op)
            2'd0:    return eq ? 32'h3f80_0000 : 32'h0;
            2'd1:    return lt ? 32'h3f80_0000 : 32'h0;
            2'd2:    return (lt || eq) ? 32'h3f80_0000 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge sys_clk) begin
        if (!rstn) begin
            u_v <= 1'b0;
        end else begin
            u_v <= cmp_valid | inject;
            u_y <= fcmp(cmp_op, cmp_x1, cmp_x2);
        end
    end
    assign cmp_out_valid = u_v;
    assign cmp_y         = u_y;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic smp();
        @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_rdy3 [8];
        logic [1:0] exp_rv3  [8];
        logic [1:0] exp_rdy4 [8];
        exp_rdy3 = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
        exp_rv3  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
        exp_rdy4 = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

        rstn      = 1'b0;
        req_valid = 2'b11;
        req_op    = '0;
        req_x1    = '0;
        req_x2    = '0;
        rsp_ready = 2'b00;
        inject    = 1'b0;

        // Reset held with both requesters asking
        for (int c = 0; c < 3; c++) begin
            cyc();
            smp();
            check("rst_req_ready", 64'(req_ready), 64'(2'b00));
            check("rst_cmp_valid", 64'(cmp_valid), 64'(1'b0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
            check("rst_err", 64'(err), 64'(1'b0));
        end

        // Single EQ op from req0
        cyc();
        rstn      = 1'b1;
        req_valid = 2'b01;
        req_op    = {2'd0, 2'd0};
        req_x1    = {32'h0, 32'h4049_0fdb};
        req_x2    = {32'h0, 32'h4049_0fdb};
        smp();
        check("eq_grant", 64'(req_ready), 64'(2'b01));
        cyc();
        req_valid = 2'b00;
        smp();
        check("eq_cmp_valid", 64'(cmp_valid), 64'(1'b1));
        check("eq_cmp_op", 64'(cmp_op), 64'(2'd0));
        check("eq_cmp_x1", 64'(cmp_x1), 64'(32'h4049_0fdb));
        check("eq_cmp_x2", 64'(cmp_x2), 64'(32'h4049_0fdb));
        cyc();
        smp();
        check("eq_rsp_early", 64'(rsp_valid), 64'(2'b00));
        check("eq_cmp_idle", 64'(cmp_valid), 64'(1'b0));
        cyc();
        smp();
        check("eq_rsp_valid", 64'(rsp_valid), 64'(2'b01));
        check("eq_rsp_y", 64'(rsp_y[31:0]), 64'(32'h3f80_0000));
        cyc();
        rsp_ready = 2'b01;
        smp();
        check("eq_rsp_hold", 64'(rsp_valid), 64'(2'b01));
        cyc();
        rsp_ready = 2'b00;
        smp();
        check("eq_rsp_drop", 64'(rsp_valid), 64'(2'b00));

        // Both requesters every cycle; pointer now favours req1
        req_op    = {2'd1, 2'd1};
        req_x1    = {32'h4000_0000, 32'h3f80_0000};
        req_x2    = {32'h3f80_0000, 32'h4000_0000};
        rsp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            cyc();
            req_valid = 2'b11;
            smp();
            check($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'(exp_rdy3[c]));
            check($sformatf("rr_rsp_valid_c%0d", c), 64'(rsp_valid), 64'(exp_rv3[c]));
            if (c == 3) check("rr_rsp_y1", 64'(rsp_y[63:32]), 64'(32'h0));
            if (c == 4) check("rr_rsp_y0", 64'(rsp_y[31:0]), 64'(32'h3f80_0000));
        end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        rsp_ready = 2'b00;
        smp();
        check("rr_drained", 64'(rsp_valid), 64'(2'b00));

        // Req0 result held by back-pressure while req1 keeps being served
        for (int d = 0; d < 8; d++) begin
            cyc();
            if (d == 0) begin
                req_valid = 2'b01;
                rsp_ready = 2'b00;
            end else if (d == 1) begin
                req_valid = 2'b11;
                rsp_ready = 2'b10;
            end
            smp();
            check($sformatf("bp_ready_d%0d", d), 64'(req_ready), 64'(exp_rdy4[d]));
            if (d >= 3) begin
                check($sformatf("bp_rsp_valid0_d%0d", d), 64'(rsp_valid[0]), 64'(1'b1));
                check($sformatf("bp_rsp_y0_d%0d", d), 64'(rsp_y[31:0]), 64'(32'h3f80_0000));
            end
        end
        cyc();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        smp();
        check("bp_release", 64'(rsp_valid), 64'(2'b11));
        cyc();
        rsp_ready = 2'b00;
        smp();
        check("bp_drained", 64'(rsp_valid), 64'(2'b00));

        // Reset the cycle after issue drops the op and the pointer
        cyc();
        req_valid = 2'b01;
        smp();
        check("rst_mid_grant", 64'(req_ready), 64'(2'b01));
        cyc();
        req_valid = 2'b00;
        rstn      = 1'b0;
        smp();
        check("rst_mid_issue", 64'(cmp_valid), 64'(1'b1));
        for (int e = 0; e < 4; e++) begin
            cyc();
            rstn = 1'b1;
            smp();
            check($sformatf("rst_mid_rsp_e%0d", e), 64'(rsp_valid), 64'(2'b00));
            check($sformatf("rst_mid_cmp_e%0d", e), 64'(cmp_valid), 64'(1'b0));
        end
        cyc();
        req_valid = 2'b11;
        smp();
        check("rst_mid_first_grant", 64'(req_ready), 64'(2'b01));
        cyc();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        cyc();
        cyc();
        cyc();
        cyc();
        rsp_ready = 2'b00;
        smp();
        check("rst_mid_drained", 64'(rsp_valid), 64'(2'b00));

        // Spurious unit result
        cyc();
        inject = 1'b1;
        smp();
        check("spur_err_before", 64'(err), 64'(1'b0));
        cyc();
        inject = 1'b0;
        smp();
        check("spur_err_latency", 64'(err), 64'(1'b0));
        for (int f = 0; f < 3; f++) begin
            cyc();
            smp();
            check($sformatf("spur_err_f%0d", f), 64'(err), 64'(EXP_ERR));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
